// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared encodings and sizing for the Hi/Lo multiply unit
//
// Purpose: operation encodings, control FSM state type and iteration-count
// derivation used by hilo_muldiv_unit and its shift-add core.
// Ports: none (package).
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  // Wide enough to count up to 32 iterations at one bit per cycle.
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ITER   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  function automatic int n_iter(input int bits_per_cycle);
    return 32 / bits_per_cycle;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// rtl/hilo_muldiv_unit_if.sv - request/result bundle between EX and the Hi/Lo unit
//
// Purpose: groups the request strobe, operands and result signals.
// Signals:
//   start      request strobe, sampled only while busy is low
//   op[2:0]    operation code (hilo_pkg OP_*)
//   a, b[31:0] rs / rt operands
//   busy       multiply-class op in flight
//   done       one-cycle pulse, hi/lo already hold the new result
//   hi, lo     architectural Hi/Lo, feed the ALU for mfhi/mflo
// Modports: master drives the request, slave (the unit) drives the results.
interface hilo_muldiv_unit_if;

  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/hilo_muldiv_unit_umul_iter.sv
// rtl/hilo_muldiv_unit_umul_iter.sv - unsigned 32x32 iterative shift-add multiplier core
//
// Purpose: retires BITS_PER_CYCLE multiplier bits per step into a 64-bit product.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   load            capture a/b, clear product and step counter
//   step            perform one shift-add step
//   a, b[31:0]      unsigned multiplicand / multiplier
//   product[63:0]   running product (final after N_ITER steps)
//   last            the current step is the final one
module umul_iter
  import hilo_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product,
  output logic        last
);

  localparam int N_ITER = n_iter(BITS_PER_CYCLE);

  logic [63:0]      mcand;
  logic [31:0]      mplier;
  logic [63:0]      prod;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      partial;

  // Sum of the multiplicand shifted by each set bit in the low multiplier slice.
  always_comb begin
    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier[i]) begin
        partial = partial + (mcand << i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= {32'd0, a};
      mplier <= b;
      prod   <= '0;
      cnt    <= '0;
    end else if (step) begin
      prod   <= prod + partial;
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
      cnt    <= cnt + 1'b1;
    end
  end

  assign product = prod;
  assign last    = (cnt == CNT_W'(N_ITER - 1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// rtl/hilo_muldiv_unit.sv - iterative multiply unit owning the architectural Hi/Lo pair
//
// Purpose: executes mult/multu/madd/msub over N_ITER cycles plus a commit
// cycle, and mthi/mtlo in a single cycle; drives Hi/Lo to the ALU continuously.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   bus          hilo_muldiv_unit_if.slave (start/op/a/b in, busy/done/hi/lo out)
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                reset,
  hilo_muldiv_unit_if.slave   bus
);

  state_e      state;
  state_e      state_nx;
  logic [2:0]  op_q;
  logic        neg_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  logic        load;
  logic        step;
  logic        last;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [63:0] prod;
  logic [63:0] p_signed;
  logic [63:0] hilo_nx;
  logic        op_signed;

  // Signed ops run the unsigned core on magnitudes; -2^31 maps onto itself,
  // which is the correct 32-bit unsigned magnitude.
  always_comb begin
    op_signed = (bus.op != OP_MULTU);
    core_a    = (op_signed && bus.a[31]) ? -bus.a : bus.a;
    core_b    = (op_signed && bus.b[31]) ? -bus.b : bus.b;
  end

  umul_iter #(
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .a       (core_a),
    .b       (core_b),
    .product (prod),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // op[2]==0 selects the four multiply-class encodings.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.op[2]) begin
          load     = 1'b1;
          state_nx = S_ITER;
        end
      end
      S_ITER: begin
        step = 1'b1;
        if (last) begin
          state_nx = S_COMMIT;
        end
      end
      S_COMMIT: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    p_signed = neg_q ? -prod : prod;
    case (op_q)
      OP_MADD: hilo_nx = {hi_q, lo_q} + p_signed;
      OP_MSUB: hilo_nx = {hi_q, lo_q} - p_signed;
      default: hilo_nx = p_signed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_MULT;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == S_COMMIT);
      if (load) begin
        op_q  <= bus.op;
        neg_q <= op_signed && (bus.a[31] ^ bus.b[31]);
      end
      if (state == S_COMMIT) begin
        {hi_q, lo_q} <= hilo_nx;
      end else if (state == S_IDLE && bus.start) begin
        if (bus.op == OP_MTHI) begin
          hi_q <= bus.a;
        end
        if (bus.op == OP_MTLO) begin
          lo_q <= bus.a;
        end
      end
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb/tb_hilo_muldiv_unit.sv - directed self-checking bench for hilo_muldiv_unit
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hilo_muldiv_unit_if bus0();
  hilo_muldiv_unit_if bus1();

  hilo_muldiv_unit #(.BITS_PER_CYCLE(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  hilo_muldiv_unit #(.BITS_PER_CYCLE(4)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int vectors = 0;
  int miscompares = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic s, input logic [2:0] o,
                       input logic [31:0] av, input logic [31:0] bv);
    if (u == 0) begin
      bus0.start = s; bus0.op = o; bus0.a = av; bus0.b = bv;
    end else begin
      bus1.start = s; bus1.op = o; bus1.a = av; bus1.b = bv;
    end
  endtask

  function automatic logic get_busy(input int u);
    return (u == 0) ? bus0.busy : bus1.busy;
  endfunction
  function automatic logic get_done(input int u);
    return (u == 0) ? bus0.done : bus1.done;
  endfunction
  function automatic logic [31:0] get_hi(input int u);
    return (u == 0) ? bus0.hi : bus1.hi;
  endfunction
  function automatic logic [31:0] get_lo(input int u);
    return (u == 0) ? bus0.lo : bus1.lo;
  endfunction

  task automatic issue(input int u, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    drive(u, 1'b1, o, av, bv);
    cyc();
    drive(u, 1'b0, o, av, bv);
  endtask

  // Issues a multiply-class op and returns in the first cycle with busy low.
  task automatic run_mul(input int u, input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input bit stray, output int bc, output int early_done);
    issue(u, o, av, bv);
    bc = 0;
    early_done = 0;
    while (get_busy(u) && bc < 200) begin
      bc++;
      if (get_done(u)) early_done++;
      if (stray) begin
        if (bc == 3) drive(u, 1'b1, OP_MTHI, 32'hDEADBEEF, 32'h0);
        else if (bc == 10) drive(u, 1'b1, OP_MULTU, 32'h00001234, 32'h00005678);
        else drive(u, 1'b0, OP_MULT, $urandom(), $urandom());
      end
      cyc();
    end
    drive(u, 1'b0, OP_MULT, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 1'b0, OP_MULT, 32'h0, 32'h0);
    drive(1, 1'b0, OP_MULT, 32'h0, 32'h0);
    cyc();
    cyc();
    reset = 1'b0;
    for (int u = 0; u < 2; u++) begin
      vectors++;
      if ({get_busy(u), get_done(u)} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_busy_done u%0d: got %b expected 00", u, {get_busy(u), get_done(u)});
      end
      vectors++;
      if ({get_hi(u), get_lo(u)} !== 64'h0) begin
        miscompares++;
        $display("FAIL reset_hilo u%0d: got %h expected 0", u, {get_hi(u), get_lo(u)});
      end
    end
  endtask

  task automatic test_reset_mid_iter();
    int bc, ed;
    issue(0, OP_MTHI, 32'h0000AAAA, 32'h0);
    vectors++;
    if (get_hi(0) !== 32'h0000AAAA) begin
      miscompares++;
      $display("FAIL midrst_pre_mthi: got %h expected 0000aaaa", get_hi(0));
    end
    issue(0, OP_MULT, 32'd7, 32'd6);
    repeat (9) cyc();
    vectors++;
    if (get_busy(0) !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_busy_before: got %b expected 1", get_busy(0));
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    vectors++;
    if ({get_busy(0), get_done(0), get_hi(0), get_lo(0)} !== 66'h0) begin
      miscompares++;
      $display("FAIL midrst_after: got busy=%b done=%b hi=%h lo=%h expected all 0",
               get_busy(0), get_done(0), get_hi(0), get_lo(0));
    end
    cyc();
    vectors++;
    if ({get_busy(0), get_done(0), get_lo(0)} !== 34'h0) begin
      miscompares++;
      $display("FAIL midrst_no_commit: got busy=%b done=%b lo=%h expected 0", get_busy(0), get_done(0), get_lo(0));
    end
    run_mul(0, OP_MULTU, 32'd3, 32'd5, 1'b0, bc, ed);
    vectors++;
    if ({get_hi(0), get_lo(0)} !== 64'd15) begin
      miscompares++;
      $display("FAIL midrst_multu_3x5: got %h expected 000000000000000f", {get_hi(0), get_lo(0)});
    end
  endtask

  task automatic test_mult_signed(input int u);
    int bc, ed;
    int exp_bc;
    exp_bc = (u == 0) ? 33 : 9;
    run_mul(u, OP_MULT, 32'hFFFFFFFD, 32'd7, (u == 0), bc, ed);
    vectors++;
    if (bc !== exp_bc) begin
      miscompares++;
      $display("FAIL mult_busy_cycles u%0d: got %0d expected %0d", u, bc, exp_bc);
    end
    vectors++;
    if (ed !== 0 || get_done(u) !== 1'b1) begin
      miscompares++;
      $display("FAIL mult_done_timing u%0d: early=%0d done=%b expected early=0 done=1", u, ed, get_done(u));
    end
    vectors++;
    if ({get_hi(u), get_lo(u)} !== 64'hFFFFFFFF_FFFFFFEB) begin
      miscompares++;
      $display("FAIL mult_m3x7 u%0d: got %h expected ffffffffffffffeb", u, {get_hi(u), get_lo(u)});
    end
    cyc();
    vectors++;
    if (get_done(u) !== 1'b0 || {get_hi(u), get_lo(u)} !== 64'hFFFFFFFF_FFFFFFEB) begin
      miscompares++;
      $display("FAIL mult_done_pulse_hold u%0d: done=%b hilo=%h expected done=0 hilo=ffffffffffffffeb",
               u, get_done(u), {get_hi(u), get_lo(u)});
    end
  endtask

  task automatic test_multu_max(input int u);
    int bc, ed;
    int exp_bc;
    exp_bc = (u == 0) ? 33 : 9;
    run_mul(u, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, bc, ed);
    vectors++;
    if (bc !== exp_bc) begin
      miscompares++;
      $display("FAIL multu_busy_cycles u%0d: got %0d expected %0d", u, bc, exp_bc);
    end
    vectors++;
    if ({get_hi(u), get_lo(u)} !== 64'hFFFFFFFE_00000001) begin
      miscompares++;
      $display("FAIL multu_max u%0d: got %h expected fffffffe00000001", u, {get_hi(u), get_lo(u)});
    end
  endtask

  task automatic test_madd_msub();
    int bc, ed;
    issue(0, OP_MTHI, 32'h12345678, 32'h0);
    issue(0, OP_MTLO, 32'hFFFFFFFF, 32'h0);
    vectors++;
    if ({get_busy(0), get_done(0), get_hi(0), get_lo(0)} !== {2'b00, 64'h12345678_FFFFFFFF}) begin
      miscompares++;
      $display("FAIL mthi_mtlo: got busy=%b done=%b hilo=%h expected 0 0 12345678ffffffff",
               get_busy(0), get_done(0), {get_hi(0), get_lo(0)});
    end
    issue(0, 3'b110, 32'h0BADF00D, 32'h0);
    issue(0, 3'b111, 32'h0BADF00D, 32'h0);
    vectors++;
    if ({get_busy(0), get_hi(0), get_lo(0)} !== {1'b0, 64'h12345678_FFFFFFFF}) begin
      miscompares++;
      $display("FAIL reserved_op: got busy=%b hilo=%h expected 0 12345678ffffffff", get_busy(0), {get_hi(0), get_lo(0)});
    end
    run_mul(0, OP_MADD, 32'd1, 32'd1, 1'b0, bc, ed);
    vectors++;
    if ({get_hi(0), get_lo(0)} !== 64'h12345679_00000000) begin
      miscompares++;
      $display("FAIL madd_carry: got %h expected 1234567900000000", {get_hi(0), get_lo(0)});
    end
    run_mul(0, OP_MSUB, 32'd2, 32'd3, 1'b0, bc, ed);
    vectors++;
    if ({get_hi(0), get_lo(0)} !== 64'h12345678_FFFFFFFA) begin
      miscompares++;
      $display("FAIL msub_borrow: got %h expected 12345678fffffffa", {get_hi(0), get_lo(0)});
    end
    run_mul(0, OP_MADD, 32'hFFFFFFFF, 32'd2, 1'b0, bc, ed);
    vectors++;
    if ({get_hi(0), get_lo(0)} !== 64'h12345678_FFFFFFF8) begin
      miscompares++;
      $display("FAIL madd_negative: got %h expected 12345678fffffff8", {get_hi(0), get_lo(0)});
    end
  endtask

  task automatic test_done_cycle_start();
    int bc, ed;
    run_mul(0, OP_MULT, 32'h80000000, 32'h80000000, 1'b0, bc, ed);
    vectors++;
    if (get_done(0) !== 1'b1 || {get_hi(0), get_lo(0)} !== 64'h40000000_00000000) begin
      miscompares++;
      $display("FAIL mult_minneg: done=%b hilo=%h expected done=1 hilo=4000000000000000",
               get_done(0), {get_hi(0), get_lo(0)});
    end
    issue(0, OP_MTLO, 32'd5, 32'h0);
    vectors++;
    if ({get_busy(0), get_done(0), get_hi(0), get_lo(0)} !== {2'b00, 64'h40000000_00000005}) begin
      miscompares++;
      $display("FAIL start_in_done_cycle: busy=%b done=%b hilo=%h expected 0 0 4000000000000005",
               get_busy(0), get_done(0), {get_hi(0), get_lo(0)});
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, OP_MULT, 32'h0, 32'h0);
    drive(1, 1'b0, OP_MULT, 32'h0, 32'h0);
    test_reset();
    test_reset_mid_iter();
    test_mult_signed(0);
    test_multu_max(0);
    test_madd_msub();
    test_done_cycle_start();
    test_mult_signed(1);
    test_multu_max(1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
- Iterative multiply unit that owns the architectural Hi/Lo register pair.
- Executes mult, multu, madd, msub, mthi and mtlo.
- Continuously drives Hi/Lo to the ALU's Hi_in/Lo_in inputs, which serve mfhi/mflo.
- Sits beside the ALU in EX. Busy stalls the pipeline while an iterative operation is in flight.

Parameters:
- BITS_PER_CYCLE, default 1: multiplier bits retired per iteration. Legal values are 1, 2 and 4. Iteration count is N_ITER = 32/BITS_PER_CYCLE.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- Start  input  1  request strobe; sampled only when Busy=0
- Op  input  3  operation: 000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO; 110 and 111 are reserved
- A  input  32  rs operand
- B  input  32  rt operand
- Busy  output  1  high while a multiply-class op is in flight
- Done  output  1  one-cycle pulse; Hi/Lo hold the new result in this same cycle
- Hi  output  32  architectural Hi, feeds ALU Hi_in
- Lo  output  32  architectural Lo, feeds ALU Lo_in

Behaviour:
- Reset: Hi=0, Lo=0, Done=0, state=IDLE (so Busy=0), iteration counter=0, internal product=0. Reset in any state aborts the in-flight op, discards the partial product and applies these values at that edge.
- States: IDLE, ITER, COMMIT. Busy = (state != IDLE), decoded directly from the state register.
- IDLE, Start=1, Op=MTHI: at that edge Hi<=A; Lo unchanged; state stays IDLE. Done is not pulsed. Single-cycle, no stall.
- IDLE, Start=1, Op=MTLO: same as MTHI, but Lo<=A and Hi unchanged.
- IDLE, Start=1, reserved Op: ignored; no state or register change.
- IDLE, Start=1, Op in {MULT, MULTU, MADD, MSUB}, at edge E0:
  - Latch Op.
  - For MULTU, latch A and B unchanged.
  - For signed ops, latch |A| and |B|, plus neg = A[31]^B[31].
  - Clear the 64-bit product and counter; go to ITER.
- ITER: each edge performs one shift-add step of BITS_PER_CYCLE bits and increments the counter. After N_ITER steps (edge E0+N_ITER), go to COMMIT.
- COMMIT, at edge E0+N_ITER+1:
  - P = neg ? -prod : prod, as a 64-bit two's complement value.
  - Write {Hi,Lo} <= P for MULT/MULTU, {Hi,Lo}+P for MADD, {Hi,Lo}-P for MSUB. All arithmetic is modulo 2^64; no overflow flag.
  - Set Done=1 for one cycle and return to IDLE.
- Latency: with BITS_PER_CYCLE=1, Busy is high for 33 cycles. Done and the new Hi/Lo are visible in the cycle after Busy falls.
- Start while Busy=1 is ignored. Operands are captured at E0 only, so A/B may change freely during ITER.
- MADD/MSUB use the Hi/Lo value held at COMMIT. Nothing else writes Hi/Lo while Busy, so this equals the value at E0.
- Start in the Done cycle is legal (state is IDLE) and is accepted normally.
- Signed -2^31 × -2^31: the magnitude 2^31 is representable in the 32-bit latch, so the product is 2^62 (Hi=0x40000000, Lo=0).
- Hi and Lo are plain registers and hold their value in all cycles except the write edges above.

Decomposition:
- Package hilo_pkg holds:
  - Op encodings: OP_MULT, OP_MULTU, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO.
  - State enum: S_IDLE, S_ITER, S_COMMIT.
  - N_ITER derivation.
- Sub-module umul_iter: unsigned 32×32 iterative shift-add core. Ports: load, step, a, b, product[63:0], last. Control FSM, sign handling and the Hi/Lo registers stay in hilo_muldiv_unit.

Test Plan:
- Reset mid-ITER: MULT 7×6, then assert Reset at cycle 10 -> Busy=0, Done=0, Hi=Lo=0 next cycle. A fresh MULTU 3×5 afterwards gives Lo=15, Hi=0.
- MULT A=-3 (0xFFFFFFFD), B=7 -> Busy high 33 cycles; Done pulses once; Hi=0xFFFFFFFF, Lo=0xFFFFFFEB. Stray Start pulses issued during Busy cause no change.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- MTHI 0x12345678, then MTLO 0xFFFFFFFF, then MADD 1×1 -> Hi=0x12345679, Lo=0x00000000 (carry across Lo). Then MSUB 2×3 -> Hi=0x12345678, Lo=0xFFFFFFFA.
- MULT 0x80000000×0x80000000 -> Hi=0x40000000, Lo=0. Issue Start (MTLO 5) in the Done cycle -> accepted; Lo=5 next cycle.
- Rerun the MULT and MULTU cases with BITS_PER_CYCLE=4 -> identical results, Busy high for 9 cycles.
